move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//  Turn controller for the 11x11 game. It shares the single board write port of the State block
//  between the human (enter/cursor) and the NNUE engine: human move, then engine search, then engine move.
//  Checks legality against the 242-bit occupancy board, bounds engine search time, and falls back to the
//  first empty cell on an engine fault. Sits between the debounced inputs/engine and State in Top.
// PARAMETERS
//  CELLS        121    board cells (11x11); also the player-1 plane offset inside board[]
//  ADDR_W       8      cell address width
//  TIMEOUT      65535  max clk cycles in ENG_WAIT before the fallback move
//  SETTLE       2      cycles after a write before game_status is trusted
// PORTS
//  clk          in   1      design clock (25 MHz domain)
//  rst_n        in   1      asynchronous active-low reset
//  restart      in   1      sync one-cycle pulse; abandon game, return to HUMAN
//  human_req    in   1      one-cycle pulse (debounced enter)
//  human_addr   in   ADDR_W cursor cell (addr0)
//  board        in   2*CELLS [a]=player0 stone, [a+CELLS]=player1 stone
//  game_status  in   2      00 playing; any other value = game over (from State)
//  eng_start    out  1      one-cycle pulse: begin search on the current board
//  eng_done     in   1      one-cycle pulse: eng_addr valid
//  eng_addr     in   ADDR_W engine-chosen cell
//  write        out  1      one-cycle board write strobe to State
//  write_addr   out  ADDR_W cell written when write=1
//  player       out  1      side to move: 0 human, 1 engine
//  busy         out  1      high in every state except HUMAN and OVER
//  err_illegal  out  1      one-cycle pulse: human move rejected
//  eng_fault    out  1      one-cycle pulse: engine timeout or illegal engine move
//  draw         out  1      sticky: board full with no winner
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HUMAN; player=0; all pulses 0; write_addr=0; draw=0; timer=0.
//  Legal(a) = a<CELLS && !board[a] && !board[a+CELLS].
//  FSM states: HUMAN, H_WRITE, H_SETTLE, ENG_START, ENG_WAIT, SCAN, E_WRITE, E_SETTLE, OVER.
//  HUMAN: human_req && Legal(human_addr) -> latch addr, go to H_WRITE.
//   human_req && !Legal -> err_illegal=1 in the next cycle; stay in HUMAN.
//  H_WRITE: write=1, write_addr=latched addr, exactly 1 cycle (req at t gives write at t+1).
//  H_SETTLE: wait SETTLE cycles. Then game_status!=0 -> OVER; else player=1 and go to ENG_START.
//  ENG_START: eng_start=1 for 1 cycle; clear timer; go to ENG_WAIT.
//  ENG_WAIT: timer increments each cycle.
//   eng_done && Legal(eng_addr) -> latch, go to E_WRITE.
//   eng_done && !Legal, or timer==TIMEOUT -> eng_fault=1, go to SCAN.
//  SCAN: the scanner walks a=0..CELLS-1 at 1 cell/cycle. First Legal a -> latch, go to E_WRITE.
//   If none is found -> draw=1, go to OVER.
//  E_WRITE: write=1 for 1 cycle. E_SETTLE: as H_SETTLE, but on success player=0 and go to HUMAN.
//  OVER: write and eng_start held 0; all human_req ignored; leave only on restart or reset.
//  human_req outside HUMAN: dropped silently; no err_illegal.
//  eng_done outside ENG_WAIT: ignored, including a late done after a timeout.
//  restart in any state (incl. mid-SCAN or ENG_WAIT): next cycle state=HUMAN, player=0, draw=0.
//   No write is issued in that cycle. The State block is reset separately by Top.
//  restart coincident with human_req: restart wins; the request is dropped.
//  At most one write strobe per turn; player changes only in the SETTLE exit cycle.
//  Timer is 17 bits; it saturates and never wraps.
// STRUCTURE
//  Shared package/include game_pkg: CELLS=121, SIDE=11, GS_PLAYING=2'b00, FSM state encodings,
//   and a Legal() function over board[].
//  One sub-module, empty_cell_scanner: ports start, board -> found, addr, done. It is the sequential
//   first-empty search, restartable by start.
// TESTING
//  1 Empty board, human_req with human_addr=60 -> write at t+1 addr 60; eng_start 1 pulse after
//    SETTLE+1 cycles; player=1.
//  2 board[60]=1, human_req with addr 60 -> err_illegal pulse, no write, state stays HUMAN;
//    addr 130 -> err_illegal.
//  3 ENG_WAIT, eng_done with eng_addr=61 on free cell -> write addr 61 one cycle later; player
//    back to 0 after settle.
//  4 eng_done never asserted, TIMEOUT=16, cells 0..4 occupied -> eng_fault at cycle 16; write
//    addr 5 after 6 scan cycles.
//  5 game_status=01 during H_SETTLE -> OVER; later human_req and eng_done produce no write;
//    restart -> HUMAN, player 0.
//  6 Board full except the move just written, engine fault -> scan finds none -> draw=1, OVER;
//    async rst_n mid-SCAN clears everything immediately.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared constants for the 11x11 game.
//  CELLS/SIDE     board geometry; CELLS is also the player-1 plane offset in board[]
//  GS_PLAYING     game_status value while the game is live
//  S_*            move_scheduler FSM state encodings
//  legal()        cell is on the board and free in both stone planes
package game_pkg;
  localparam int CELLS   = 121;
  localparam int SIDE    = 11;
  localparam int BOARD_W = 2*CELLS;

  localparam logic [1:0] GS_PLAYING = 2'b00;

  localparam logic [3:0] S_HUMAN     = 4'd0;
  localparam logic [3:0] S_H_WRITE   = 4'd1;
  localparam logic [3:0] S_H_SETTLE  = 4'd2;
  localparam logic [3:0] S_ENG_START = 4'd3;
  localparam logic [3:0] S_ENG_WAIT  = 4'd4;
  localparam logic [3:0] S_SCAN      = 4'd5;
  localparam logic [3:0] S_E_WRITE   = 4'd6;
  localparam logic [3:0] S_E_SETTLE  = 4'd7;
  localparam logic [3:0] S_OVER      = 4'd8;

  // Masking instead of bit-selects keeps an off-board address from
  // indexing past the vector; the range test decides those anyway.
  function automatic logic legal(input logic [BOARD_W-1:0] board,
                                 input logic [7:0] a);
    logic [BOARD_W-1:0] one;
    one = BOARD_W'(1);
    return (32'(a) < CELLS) &&
           ((board & ((one << a) | (one << (32'(a) + CELLS)))) == '0);
  endfunction
endpackage

// File: rtl/empty_cell_scanner.sv
// empty_cell_scanner: sequential first-empty-cell search, one cell per cycle.
//  clk, rst_n   clock, async active-low reset
//  start        pulse: (re)start the walk at cell 0 on the next cycle
//  board        occupancy, both planes
//  found        this cycle's cell is empty (valid with done)
//  addr         cell currently examined
//  done         walk ends this cycle: empty cell found or last cell examined
module empty_cell_scanner
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BOARD_W-1:0] board,
  output logic               found,
  output logic [7:0]         addr,
  output logic               done
);
  logic [7:0] idx;
  logic       active;
  logic       hit;

  assign hit   = legal(board, idx);
  assign found = active && hit;
  assign done  = active && (hit || idx == 8'(CELLS-1));
  assign addr  = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      active <= 1'b0;
    end else if (start) begin
      idx    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (done) active <= 1'b0;
      else      idx    <= idx + 8'd1;
    end
  end
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: turn controller sharing State's single board write port
// between the human and the engine (human move, engine search, engine move).
//  clk, rst_n    clock, async active-low reset
//  restart       pulse: abandon the game, back to HUMAN
//  human_req     pulse with human_addr: human wants to play that cell
//  board         occupancy, [a]=player0, [a+CELLS]=player1
//  game_status   00 playing, anything else game over
//  eng_start     pulse: engine begins searching
//  eng_done      pulse with eng_addr: engine's chosen cell
//  write         board write strobe, write_addr the cell
//  player        side to move (0 human, 1 engine)
//  busy          mid-turn (not HUMAN, not OVER)
//  err_illegal   pulse: human move rejected
//  eng_fault     pulse: engine timed out or chose an illegal cell
//  draw          sticky: no empty cell left for the fallback move
module move_scheduler
  import game_pkg::*;
#(
  parameter int CELLS   = game_pkg::CELLS,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65535,
  parameter int SETTLE  = 2          // must be >= 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               human_req,
  input  logic [ADDR_W-1:0]  human_addr,
  input  logic [2*CELLS-1:0] board,
  input  logic [1:0]         game_status,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic [ADDR_W-1:0]  eng_addr,
  output logic               write,
  output logic [ADDR_W-1:0]  write_addr,
  output logic               player,
  output logic               busy,
  output logic               err_illegal,
  output logic               eng_fault,
  output logic               draw
);
  logic [3:0]  state;
  logic [16:0] timer;
  logic [7:0]  settle_cnt;
  logic        h_legal, e_legal, accept, fault;
  logic        sc_found, sc_done;
  logic [7:0]  sc_addr;

  assign h_legal = legal(board, 8'(human_addr));
  assign e_legal = legal(board, 8'(eng_addr));

  // A legal answer arriving in the timeout cycle still wins.
  assign accept = (state == S_ENG_WAIT) && eng_done && e_legal;
  assign fault  = (state == S_ENG_WAIT) && !restart && !accept &&
                  (eng_done || timer == 17'(TIMEOUT));

  // Fault is flagged in the deciding cycle and kicks the scanner off in
  // that same cycle, so SCAN's first cycle already examines cell 0.
  assign eng_fault = fault;
  assign eng_start = (state == S_ENG_START);
  assign write     = (state == S_H_WRITE) || (state == S_E_WRITE);
  assign busy      = !((state == S_HUMAN) || (state == S_OVER));

  empty_cell_scanner u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .start (fault),
    .board (board),
    .found (sc_found),
    .addr  (sc_addr),
    .done  (sc_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HUMAN;
      player      <= 1'b0;
      write_addr  <= '0;
      draw        <= 1'b0;
      timer       <= '0;
      settle_cnt  <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      if (restart) begin
        state  <= S_HUMAN;
        player <= 1'b0;
        draw   <= 1'b0;
      end else begin
        case (state)
          S_HUMAN:
            if (human_req) begin
              if (h_legal) begin
                write_addr <= human_addr;
                state      <= S_H_WRITE;
              end else begin
                err_illegal <= 1'b1;
              end
            end
          S_H_WRITE: begin
            settle_cnt <= '0;
            state      <= S_H_SETTLE;
          end
          S_H_SETTLE:
            if (settle_cnt == 8'(SETTLE-1)) begin
              if (game_status != GS_PLAYING) state <= S_OVER;
              else begin
                player <= 1'b1;
                state  <= S_ENG_START;
              end
            end else settle_cnt <= settle_cnt + 8'd1;
          S_ENG_START: begin
            timer <= '0;
            state <= S_ENG_WAIT;
          end
          S_ENG_WAIT: begin
            if (timer != '1) timer <= timer + 17'd1;
            if (accept) begin
              write_addr <= eng_addr;
              state      <= S_E_WRITE;
            end else if (fault) state <= S_SCAN;
          end
          S_SCAN:
            if (sc_done) begin
              if (sc_found) begin
                write_addr <= ADDR_W'(sc_addr);
                state      <= S_E_WRITE;
              end else begin
                draw  <= 1'b1;
                state <= S_OVER;
              end
            end
          S_E_WRITE: begin
            settle_cnt <= '0;
            state      <= S_E_SETTLE;
          end
          S_E_SETTLE:
            if (settle_cnt == 8'(SETTLE-1)) begin
              if (game_status != GS_PLAYING) state <= S_OVER;
              else begin
                player <= 1'b0;
                state  <= S_HUMAN;
              end
            end else settle_cnt <= settle_cnt + 8'd1;
          S_OVER: ;
          default: state <= S_HUMAN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
  import game_pkg::*;
  localparam int AW = 8;

  logic clk = 1'b0, rst_n = 1'b0, restart = 1'b0, human_req = 1'b0, eng_done = 1'b0;
  logic [AW-1:0] human_addr = '0, eng_addr = '0;
  logic [2*CELLS-1:0] board = '0;
  logic [1:0] game_status = 2'b00;
  logic eng_start, write, player, busy, err_illegal, eng_fault, draw;
  logic [AW-1:0] write_addr;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  move_scheduler #(.CELLS(CELLS), .ADDR_W(AW), .TIMEOUT(16), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .human_req(human_req),
    .human_addr(human_addr), .board(board), .game_status(game_status),
    .eng_start(eng_start), .eng_done(eng_done), .eng_addr(eng_addr),
    .write(write), .write_addr(write_addr), .player(player), .busy(busy),
    .err_illegal(err_illegal), .eng_fault(eng_fault), .draw(draw)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; restart = 1'b0; human_req = 1'b0; eng_done = 1'b0;
    game_status = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // From HUMAN: play cell a and stop at the ENG_START cycle.
  task automatic human_to_eng(input int a);
    human_addr = AW'(a); human_req = 1'b1;
    tick();
    human_req = 1'b0; board[a] = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({player, write, busy, draw, eng_start, err_illegal, eng_fault} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {player, write, busy, draw, eng_start, err_illegal, eng_fault});
    end
    checks++;
    if (write_addr !== 8'd0) begin
      failures++; $display("FAIL reset_write_addr got=%0d exp=0", write_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_human_move();
    board = '0;
    human_addr = 8'd60; human_req = 1'b1;
    tick();
    human_req = 1'b0;
    checks++;
    if ({write, busy, player} !== 3'b110) begin
      failures++; $display("FAIL hm_write got=%b exp=110", {write, busy, player});
    end
    checks++;
    if (write_addr !== 8'd60) begin
      failures++; $display("FAIL hm_write_addr got=%0d exp=60", write_addr);
    end
    board[60] = 1'b1;
    tick();
    checks++;
    if ({write, eng_start} !== 2'b00) begin
      failures++; $display("FAIL hm_settle0 got=%b exp=00", {write, eng_start});
    end
    tick();
    checks++;
    if ({eng_start, player} !== 2'b00) begin
      failures++; $display("FAIL hm_settle1 got=%b exp=00", {eng_start, player});
    end
    tick();
    checks++;
    if ({eng_start, player} !== 2'b11) begin
      failures++; $display("FAIL hm_eng_start got=%b exp=11", {eng_start, player});
    end
    tick();
    checks++;
    if ({eng_start, busy} !== 2'b01) begin
      failures++; $display("FAIL hm_eng_wait got=%b exp=01", {eng_start, busy});
    end
  endtask

  task automatic test_engine_move();
    eng_addr = 8'd61; eng_done = 1'b1;
    #1;
    checks++;
    if (eng_fault !== 1'b0) begin
      failures++; $display("FAIL em_no_fault got=%b exp=0", eng_fault);
    end
    tick();
    eng_done = 1'b0;
    checks++;
    if ({write, player} !== 2'b11 || write_addr !== 8'd61) begin
      failures++;
      $display("FAIL em_write got=%b addr=%0d exp=11 addr=61", {write, player}, write_addr);
    end
    board[61+CELLS] = 1'b1;
    tick();
    checks++;
    if ({write, player} !== 2'b01) begin
      failures++; $display("FAIL em_settle0 got=%b exp=01", {write, player});
    end
    tick();
    checks++;
    if (player !== 1'b1) begin
      failures++; $display("FAIL em_settle1 player got=%b exp=1", player);
    end
    tick();
    checks++;
    if ({player, busy} !== 2'b00) begin
      failures++; $display("FAIL em_human got=%b exp=00", {player, busy});
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bad [4];
    bad = '{8'd60, 8'd61, 8'd121, 8'd130};
    for (int i = 0; i < 4; i++) begin
      human_addr = bad[i]; human_req = 1'b1;
      tick();
      human_req = 1'b0;
      checks++;
      if ({err_illegal, write, busy} !== 3'b100) begin
        failures++;
        $display("FAIL illegal_%0d got=%b exp=100", bad[i], {err_illegal, write, busy});
      end
      tick();
      checks++;
      if ({err_illegal, write} !== 2'b00) begin
        failures++;
        $display("FAIL illegal_pulse_%0d got=%b exp=00", bad[i], {err_illegal, write});
      end
    end
  endtask

  task automatic test_timeout();
    int k, n;
    do_reset();
    board = '0;
    board[0] = 1'b1; board[1] = 1'b1; board[2] = 1'b1;
    board[3+CELLS] = 1'b1; board[4+CELLS] = 1'b1;
    human_to_eng(100);
    checks++;
    if (eng_start !== 1'b1) begin
      failures++; $display("FAIL to_eng_start got=%b exp=1", eng_start);
    end
    k = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (eng_fault === 1'b1) begin k = i; break; end
    end
    checks++;
    if (k != 16) begin
      failures++; $display("FAIL to_fault_cycle got=%0d exp=16", k);
    end
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (eng_fault !== 1'b0) begin
          failures++; $display("FAIL to_fault_pulse got=%b exp=0", eng_fault);
        end
        eng_addr = 8'd50; eng_done = 1'b1;   // late answer, must be ignored
      end else eng_done = 1'b0;
      if (write === 1'b1) begin n = i; break; end
    end
    eng_done = 1'b0;
    checks++;
    if (n != 7 || write_addr !== 8'd5) begin
      failures++; $display("FAIL to_scan_write got=%0d addr=%0d exp=7 addr=5", n, write_addr);
    end
    board[5+CELLS] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({player, busy} !== 2'b00) begin
      failures++; $display("FAIL to_back_human got=%b exp=00", {player, busy});
    end
  endtask

  task automatic test_game_over();
    do_reset();
    board = '0;
    human_addr = 8'd10; human_req = 1'b1;
    tick();
    human_req = 1'b0; board[10] = 1'b1;
    tick();
    game_status = 2'b01;
    tick(); tick();
    checks++;
    if ({busy, player, eng_start} !== 3'b000) begin
      failures++; $display("FAIL go_over got=%b exp=000", {busy, player, eng_start});
    end
    human_addr = 8'd20; human_req = 1'b1;
    tick();
    human_req = 1'b0;
    checks++;
    if ({write, err_illegal} !== 2'b00) begin
      failures++; $display("FAIL go_req_ignored got=%b exp=00", {write, err_illegal});
    end
    eng_addr = 8'd30; eng_done = 1'b1;
    #1;
    checks++;
    if (eng_fault !== 1'b0) begin
      failures++; $display("FAIL go_done_fault got=%b exp=0", eng_fault);
    end
    tick();
    eng_done = 1'b0;
    tick();
    checks++;
    if ({write, busy} !== 2'b00) begin
      failures++; $display("FAIL go_done_ignored got=%b exp=00", {write, busy});
    end
    restart = 1'b1;
    tick();
    restart = 1'b0; game_status = 2'b00;
    human_addr = 8'd20; human_req = 1'b1;
    tick();
    human_req = 1'b0;
    checks++;
    if ({write, player} !== 2'b10 || write_addr !== 8'd20) begin
      failures++;
      $display("FAIL go_restart got=%b addr=%0d exp=10 addr=20", {write, player}, write_addr);
    end
  endtask

  task automatic test_restart();
    do_reset();
    board = '0;
    human_addr = 8'd40; human_req = 1'b1; restart = 1'b1;
    tick();
    human_req = 1'b0; restart = 1'b0;
    checks++;
    if ({write, err_illegal, busy} !== 3'b000) begin
      failures++; $display("FAIL rs_coincident got=%b exp=000", {write, err_illegal, busy});
    end
    human_to_eng(40);
    tick(); tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({busy, player, write} !== 3'b000) begin
      failures++; $display("FAIL rs_eng_wait got=%b exp=000", {busy, player, write});
    end
    eng_addr = 8'd41; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checks++;
    if ({write, busy} !== 2'b00) begin
      failures++; $display("FAIL rs_late_done got=%b exp=00", {write, busy});
    end
  endtask

  task automatic test_draw();
    int k;
    logic wr;
    do_reset();
    board = '0;
    for (int a = 0; a < CELLS-1; a++) begin
      if (a % 2 == 1) board[a+CELLS] = 1'b1;
      else            board[a]       = 1'b1;
    end
    human_to_eng(120);
    tick();
    eng_addr = 8'd120; eng_done = 1'b1;
    #1;
    checks++;
    if (eng_fault !== 1'b1) begin
      failures++; $display("FAIL dr_illegal_fault got=%b exp=1", eng_fault);
    end
    tick();
    eng_done = 1'b0;
    k = -1; wr = 1'b0;
    for (int i = 2; i <= 300; i++) begin
      tick();
      if (write === 1'b1) wr = 1'b1;
      if (draw === 1'b1) begin k = i; break; end
    end
    checks++;
    if (k != 122 || wr !== 1'b0) begin
      failures++; $display("FAIL dr_scan got=%0d wrote=%b exp=122 wrote=0", k, wr);
    end
    human_addr = 8'd0; human_req = 1'b1;
    tick();
    human_req = 1'b0;
    tick();
    checks++;
    if ({draw, busy, player, write, err_illegal} !== 5'b10100) begin
      failures++;
      $display("FAIL dr_over got=%b exp=10100", {draw, busy, player, write, err_illegal});
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({draw, player, busy} !== 3'b000) begin
      failures++; $display("FAIL dr_restart got=%b exp=000", {draw, player, busy});
    end
    board[120] = 1'b0;
    human_to_eng(120);
    tick();
    eng_addr = 8'd120; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    repeat (10) tick();
    checks++;
    if ({busy, player} !== 2'b11) begin
      failures++; $display("FAIL dr_mid_scan got=%b exp=11", {busy, player});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, player, draw} !== 3'b000 || write_addr !== 8'd0) begin
      failures++;
      $display("FAIL dr_async_reset got=%b addr=%0d exp=000 addr=0", {busy, player, draw}, write_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_human_move();
    test_engine_move();
    test_illegal();
    test_timeout();
    test_game_over();
    test_restart();
    test_draw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
